// File: rtl/bp_fe_ras_ckpt_ctrl.sv
// bp_fe_ras_ckpt_ctrl
//   Checkpoint controller for the front-end return address stack (RAS).
//   Every in-flight control-flow instruction gets a snapshot of the RAS
//   {next, tos} pointers, held in a ring buffer. Snapshots retire in order
//   on commit. A squash or flush produces a one-cycle pointer restore into
//   the RAS. Call/return toward the RAS are gated off until the RAS has
//   finished initialising, and also while a restore is in progress.
//
//   ras_idx_width_p is the RAS pointer width that the processor
//   configuration would normally supply.
//
// Ports
//   clk_i, reset_i            clock and async active-high reset
//   ras_init_done_i           RAS storage clear has completed
//   ras_next_i, ras_tos_i     live RAS pointers, snapshotted on alloc
//   call_i, return_i          predicted call/return from fetch
//   call_o, return_o          gated call/return to RAS
//   restore_o                 restore strobe, with w_next_o / w_tos_o
//   alloc_v_i                 request a checkpoint
//   alloc_ready_o, alloc_id_o the request is accepted, and the id it gets
//   commit_v_i                retire the oldest checkpoint
//   squash_v_i, squash_id_i   restore to a checkpoint and free it plus all younger ones
//   flush_i                   restore to the oldest checkpoint and free all
//   empty_o, full_o           ring occupancy
//
// State table
//   e_wait    | RAS still initialising; everything is gated
//   e_run     | normal operation
//   e_restore | restore strobe cycle; call/return are blocked
module bp_fe_ras_ckpt_ctrl #(
  parameter int ras_idx_width_p = 3,
  parameter int ckpt_els_p      = 8,
  localparam int ckpt_id_width_p = $clog2(ckpt_els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       ras_init_done_i,
  input  logic [ras_idx_width_p-1:0] ras_next_i,
  input  logic [ras_idx_width_p-1:0] ras_tos_i,
  input  logic                       call_i,
  input  logic                       return_i,
  output logic                       call_o,
  output logic                       return_o,
  output logic                       restore_o,
  output logic [ras_idx_width_p-1:0] w_next_o,
  output logic [ras_idx_width_p-1:0] w_tos_o,
  input  logic                       alloc_v_i,
  output logic                       alloc_ready_o,
  output logic [ckpt_id_width_p-1:0] alloc_id_o,
  input  logic                       commit_v_i,
  input  logic                       squash_v_i,
  input  logic [ckpt_id_width_p-1:0] squash_id_i,
  input  logic                       flush_i,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam logic [1:0] e_wait    = 2'd0;
  localparam logic [1:0] e_run     = 2'd1;
  localparam logic [1:0] e_restore = 2'd2;

  localparam int ptr_w = ckpt_id_width_p + 1;
  localparam logic [ptr_w-1:0] ptr_one = ptr_w'(1);

  logic [1:0]                       state_r, state_n;
  logic [ptr_w-1:0]                 head_r, tail_r, head_n, tail_n;
  logic [ptr_w-1:0]                 live_cnt, squash_ptr;
  logic [ckpt_id_width_p-1:0]       head_idx, tail_idx, squash_ofs, rd_idx;
  logic [2*ras_idx_width_p-1:0]     mem [ckpt_els_p];
  logic [ras_idx_width_p-1:0]       w_next_r, w_tos_r;
  logic                             run, squash_live;
  logic                             flush_acc, squash_acc, restore_acc;
  logic                             commit_acc, alloc_acc;

  assign run      = (state_r == e_run);
  assign head_idx = head_r[ckpt_id_width_p-1:0];
  assign tail_idx = tail_r[ckpt_id_width_p-1:0];

  assign empty_o = (head_r == tail_r);
  assign full_o  = (head_idx == tail_idx) && (head_r[ckpt_id_width_p] != tail_r[ckpt_id_width_p]);

  // Liveness is tested as a distance from head. This stays correct across
  // wrap-around, and head + distance gives the pointer with the right wrap bit.
  assign squash_ofs  = squash_id_i - head_idx;
  assign live_cnt    = tail_r - head_r;
  assign squash_live = ({1'b0, squash_ofs} < live_cnt);
  assign squash_ptr  = head_r + {1'b0, squash_ofs};

  assign flush_acc   = run & flush_i & ~empty_o;
  assign squash_acc  = run & ~flush_i & squash_v_i & squash_live;
  assign restore_acc = flush_acc | squash_acc;
  // Squashing the head entry already frees it, so a commit in the same cycle must not retire it again.
  assign commit_acc  = run & commit_v_i & ~empty_o & ~flush_i & ~(squash_acc & (squash_ofs == '0));

  assign alloc_ready_o = run & ~full_o & ~squash_v_i & ~flush_i;
  assign alloc_acc     = alloc_v_i & alloc_ready_o;
  assign alloc_id_o    = tail_idx;

  assign call_o    = call_i   & run & ~squash_v_i & ~flush_i;
  assign return_o  = return_i & run & ~squash_v_i & ~flush_i;
  assign restore_o = (state_r == e_restore);
  assign w_next_o  = w_next_r;
  assign w_tos_o   = w_tos_r;

  assign rd_idx = flush_acc ? head_idx : squash_id_i;

  always_comb begin
    state_n = state_r;
    head_n  = head_r;
    tail_n  = tail_r;
    case (state_r)
      e_wait:    if (ras_init_done_i) state_n = e_run;
      e_run:     if (restore_acc)     state_n = e_restore;
      e_restore: state_n = e_run;
      default:   state_n = e_wait;
    endcase
    if (commit_acc) head_n = head_r + ptr_one;
    if (flush_acc)       tail_n = head_r;
    else if (squash_acc) tail_n = squash_ptr;
    else if (alloc_acc)  tail_n = tail_r + ptr_one;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r  <= e_wait;
      head_r   <= '0;
      tail_r   <= '0;
      w_next_r <= '0;
      w_tos_r  <= '0;
    end else begin
      state_r <= state_n;
      head_r  <= head_n;
      tail_r  <= tail_n;
      if (restore_acc) {w_next_r, w_tos_r} <= mem[rd_idx];
    end
  end

  // Snapshot storage needs no reset; an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (alloc_acc) mem[tail_idx] <= {ras_next_i, ras_tos_i};
  end

endmodule
